// File: rtl/mult_unit.sv
// Iterative shift-add multiplier, signed (MULT) or unsigned (MULTU), 2*WIDTH-bit product on hi/lo.
// Latency: done pulses in the cycle after the (WIDTH+1)th rising edge following the accepting edge.
// No backpressure: start is only sampled in IDLE; starts while busy are dropped, flush aborts.
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             neg_result,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Counter must hold the value WIDTH itself, hence WIDTH+1.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Upper half collects partial sums, lower half starts as the multiplier
  // and is shifted out LSB-first as product bits shift in.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               neg_q, neg_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] result;

  // Operand magnitudes; negating the most-negative value wraps to 2^(WIDTH-1),
  // which is exactly the right unsigned magnitude.
  always_comb begin
    mag_a = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    mag_b = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  end

  // One shift-add step and the final sign fix-up of the accumulator.
  always_comb begin
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    result = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
  end

  // Next-state and datapath control; flush overrides everything and keeps hi/lo.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = CW'(WIDTH);
          acc_d   = {{WIDTH{1'b0}}, mag_b};
          mcand_d = mag_a;
          neg_d   = is_signed & neg_result;
        end
      end
      RUN: begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        {hi_d, lo_d} = result;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush) begin
      state_d = IDLE;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN) || (state_q == FIX);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_unit.sv
// Directed bench for mult_unit (WIDTH=32) with hand-computed products.
// Checks latency, busy window, flush/reset aborts and ignored starts.
// All comparisons go through chk.
module tb_mult_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        neg_result;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] av;
    logic [31:0] bv;
    logic        sg;
    logic        ng;
    logic [63:0] prod;
  } vec_t;

  vec_t vecs [9];

  mult_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_signed  (is_signed),
    .a          (a),
    .b          (b),
    .neg_result (neg_result),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch one multiply and wait (bounded) for done. now=1 drives start
  // in the current cycle instead of waiting for the next negedge.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic sg,
                        input logic ng, input bit now, output int lat, output int bcnt);
    if (!now) @(negedge clk);
    a = av; b = bv; is_signed = sg; neg_result = ng; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; is_signed = 1'($urandom); neg_result = 1'($urandom);
    bcnt = busy ? 1 : 0;
    lat = -1;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (done) lat = n;
      else if (busy) bcnt++;
    end
  endtask

  initial begin
    int lat, bcnt, nd;
    logic [31:0] hv, lv;

    vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE_00000001};
    vecs[1] = '{32'hFFFFFFFD, 32'h00000005, 1'b1, 1'b1, 64'hFFFFFFFF_FFFFFFF1};
    vecs[2] = '{32'hFFFFFFFD, 32'hFFFFFFFB, 1'b1, 1'b0, 64'h00000000_0000000F};
    vecs[3] = '{32'h80000000, 32'h80000000, 1'b1, 1'b0, 64'h40000000_00000000};
    vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 64'hFFFFFFFF_80000000};
    vecs[5] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 64'h00000000_FFFFFFFF};
    vecs[6] = '{32'h00000000, 32'hFFFFFFF9, 1'b1, 1'b1, 64'h00000000_00000000};
    vecs[7] = '{32'h12345678, 32'h00000010, 1'b0, 1'b0, 64'h00000001_23456780};
    vecs[8] = '{32'h00000007, 32'hFFFFFFFF, 1'b1, 1'b1, 64'hFFFFFFFF_FFFFFFF9};

    reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    neg_result = 1'b0; flush = 1'b0;

    // Reset values, then release just after an edge so the next edge is the first one.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    #1 reset = 1'b0;

    // Directed vectors; vector 1 is started in the done cycle of vector 0.
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].av, vecs[i].bv, vecs[i].sg, vecs[i].ng, (i == 1), lat, bcnt);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
      chk($sformatf("vec%0d_product", i), {hi, lo}, vecs[i].prod);
      chk($sformatf("vec%0d_busy_at_done", i), 64'(busy), 64'd0);
      if (i == 0) chk("vec0_busy_cycles", 64'(bcnt), 64'd33);
    end
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("hold_after_done", {hi, lo}, vecs[8].prod);

    // Second start at cycle 10 of a busy op is dropped.
    @(negedge clk);
    a = 32'd3; b = 32'd4; is_signed = 1'b0; neg_result = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0; lat = -1; hv = '0; lv = '0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (done) begin
        nd++;
        if (lat < 0) begin lat = n; hv = hi; lv = lo; end
      end
      start = (n == 10);
      if (n == 10) begin a = 32'd9; b = 32'd9; end
    end
    chk("busy_start_done_count", 64'(nd), 64'd1);
    chk("busy_start_latency", 64'(lat), 64'd33);
    chk("busy_start_product", {hv, lv}, 64'd12);

    // Flush at cycle 15 aborts, no done, hi/lo keep 12.
    @(negedge clk);
    a = 32'd5; b = 32'd5; is_signed = 1'b0; neg_result = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk); #1;
      if (done) nd++;
      if (n == 16) chk("flush_idle", 64'(busy), 64'd0);
      flush = (n == 15);
    end
    chk("flush_no_done", 64'(nd), 64'd0);
    chk("flush_hold", {hi, lo}, 64'd12);
    run_op(32'd5, 32'd5, 1'b0, 1'b0, 1'b0, lat, bcnt);
    chk("post_flush_latency", 64'(lat), 64'd33);
    chk("post_flush_product", {hi, lo}, 64'd25);

    // Flush and start together: flush wins.
    @(negedge clk);
    a = 32'd2; b = 32'd2; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", 64'(busy), 64'd0);
    nd = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("flush_start_no_done", 64'(nd), 64'd0);
    chk("flush_start_hold", {hi, lo}, 64'd25);

    // Reset between edges mid-RUN clears immediately; no done afterwards.
    @(negedge clk);
    a = 32'd6; b = 32'd7; is_signed = 1'b0; neg_result = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("midrun_rst_busy", 64'(busy), 64'd0);
    chk("midrun_rst_hilo", {hi, lo}, 64'd0);
    chk("midrun_rst_done", 64'(done), 64'd0);
    @(posedge clk); #2 reset = 1'b0;
    nd = 0;
    for (int n = 1; n <= 45; n++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("midrun_rst_no_done", 64'(nd), 64'd0);
    run_op(32'd6, 32'd7, 1'b0, 1'b0, 1'b0, lat, bcnt);
    chk("post_rst_latency", 64'(lat), 64'd33);
    chk("post_rst_product", {hi, lo}, 64'd42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiply, sampled only in IDLE.
REQ-005 The block SHALL have port is_signed, input, 1 bit: 1 selects MULT (two's complement), 0 selects MULTU.
REQ-006 The block SHALL have port a, input, WIDTH bits: multiplicand, sampled with start.
REQ-007 The block SHALL have port b, input, WIDTH bits: multiplier, sampled with start.
REQ-008 The block SHALL have port neg_result, input, 1 bit: a[WIDTH-1] XOR b[WIDTH-1], driven by the upstream XOR gate and sampled with start.
REQ-009 The block SHALL have port flush, input, 1 bit: pipeline flush that aborts any operation in progress.
REQ-010 The block SHALL have port busy, output, 1 bit: high while an operation is in progress (RUN or FIX).
REQ-011 The block SHALL have port done, output, 1 bit, registered: a one-cycle pulse when hi/lo are updated.
REQ-012 The block SHALL have port hi, output, WIDTH bits, registered: upper half of the 2*WIDTH-bit product.
REQ-013 The block SHALL have port lo, output, WIDTH bits, registered: lower half of the product.

Function
REQ-014 The block SHALL implement the states IDLE, RUN and FIX.
REQ-015 IDLE SHALL go to RUN on start=1 and flush=0, capturing the operand magnitudes, is_signed and neg_result, and loading the iteration counter with WIDTH.
REQ-016 Magnitudes SHALL be |a| and |b| when is_signed=1, and a and b unmodified when is_signed=0.
REQ-017 The magnitude of the most-negative value SHALL be 2^(WIDTH-1), held as an unsigned WIDTH-bit quantity without overflow.
REQ-018 RUN SHALL perform one shift-add step per cycle (the multiplier LSB conditionally adds the multiplicand into a 2*WIDTH-bit accumulator) and decrement the counter.
REQ-019 RUN SHALL go to FIX after exactly WIDTH steps.
REQ-020 FIX SHALL write the two's complement negation of the accumulator to {hi,lo} when is_signed=1 and neg_result=1, and the accumulator unmodified otherwise; it SHALL then assert done for one cycle and go to IDLE.
REQ-021 Latency: done SHALL be high, and hi/lo valid, in the cycle after the (WIDTH+1)th rising edge following the edge that accepted start.
REQ-022 busy SHALL be 1 exactly while the state is RUN or FIX, and busy and done SHALL never be high together.
REQ-023 start while busy=1 SHALL be ignored, with no queuing.
REQ-024 start in the cycle done=1 SHALL be accepted normally.
REQ-025 hi/lo SHALL hold their last written values until the next FIX.
REQ-026 Outside IDLE, the block SHALL ignore changes on a, b, is_signed and neg_result.
REQ-027 neg_result SHALL be ignored when is_signed=0.
REQ-028 A zero product SHALL yield hi=lo=0 regardless of neg_result.
REQ-029 flush=1 in any state SHALL force IDLE on the next edge, suppress done and leave hi/lo unchanged.
REQ-030 flush and start in the same cycle: flush SHALL win and the operation SHALL not start.

Reset
REQ-031 While reset=1, the block SHALL hold state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0 and accumulator=0, asynchronously and independently of clk.
REQ-032 Reset asserted mid-operation SHALL abandon the operation with no done pulse.
REQ-033 After reset deasserts, the first start SHALL be accepted on the first rising edge.

Verification (WIDTH=32)
REQ-034 The bench SHALL cover: unsigned 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done at edge 33 after the start edge, and busy high for 33 cycles.
REQ-035 The bench SHALL cover: signed -3*5 (neg_result=1) -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; and signed -3*-5 -> hi=0, lo=0x0000000F.
REQ-036 The bench SHALL cover: signed 0x80000000*0x80000000 (neg_result=0) -> hi=0x40000000, lo=0x00000000; and signed 0x80000000*1 -> hi=0xFFFFFFFF, lo=0x80000000.
REQ-037 The bench SHALL cover: a second start at cycle 10 of a busy operation -> ignored, and exactly one done with the first operation's result.
REQ-038 The bench SHALL cover: flush at cycle 15 of an operation -> IDLE next cycle, no done, and hi/lo keep the previous result; then a new start completes normally.
REQ-039 The bench SHALL cover: reset asserted mid-RUN between clock edges -> busy=0 and hi=lo=0 immediately, with no done afterwards.
